scnn_decompression_ips: RTL and testbench

Sequential decoder for the SCNN compressed input-activation format: accepts one compressed frame (four 16-entry slices of non-zero values, each tagged with a zero-run index, plus per-slice non-zero counts) and rebuilds the dense 64-entry activation vector. It sits between the compressed activation buffer and any consumer needing dense data, such as output write-back checking or the reference model path. It is the inverse of the combinational compressor. Zero-run indices count zeros since the previous non-zero, and the run continues across slice boundaries.

---
 rtl/scnn_comp_pkg.sv | 33 +++
 rtl/scnn_dense_buf.sv | 27 ++
 rtl/scnn_decompression_ips.sv | 131 +++++++++++++
 tb/tb_scnn_decompression_ips.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scnn_comp_pkg.sv
// Shared constants and frame types for the SCNN activation compressor and
// decompressor.
package scnn_comp_pkg;

  localparam int NUM_SLICES = 4;
  localparam int SLICE_LEN  = 16;
  localparam int DATA_W     = 16;
  localparam int IDX_W      = 8;
  localparam int DENSE_LEN  = 64;
  localparam int CNT_W      = 8;
  localparam int POS_W      = $clog2(DENSE_LEN);
  localparam int SLICE_W    = $clog2(NUM_SLICES);
  localparam int ENTRY_W    = $clog2(SLICE_LEN) + 1;
  localparam int SUM_W      = 9;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_t;

  typedef logic [NUM_SLICES-1:0][SLICE_LEN-1:0][DATA_W-1:0] comp_val_t;
  typedef logic [NUM_SLICES-1:0][SLICE_LEN-1:0][IDX_W-1:0]  comp_idx_t;
  typedef logic [NUM_SLICES-1:0][CNT_W-1:0]                 ips_t;
  typedef logic [DENSE_LEN-1:0][DATA_W-1:0]                 dense_t;

  // A slice never holds more than SLICE_LEN entries, whatever its count claims.
  function automatic logic [ENTRY_W-1:0] clampLen(input logic [CNT_W-1:0] ips);
    if (ips > CNT_W'(SLICE_LEN)) return ENTRY_W'(SLICE_LEN);
    return ips[ENTRY_W-1:0];
  endfunction

endpackage

// File: rtl/scnn_dense_buf.sv
// Dense activation register file: synchronous clear, one write port and a
// full parallel read of every entry.
module scnn_dense_buf
  import scnn_comp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [POS_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output dense_t            rdata_o
);

  dense_t mem_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q;

endmodule

// File: rtl/scnn_decompression_ips.sv
// SCNN activation decompressor: walks the four compressed slices one entry per
// cycle and rebuilds the dense 64-entry vector in scnn_dense_buf.
module scnn_decompression_ips
  import scnn_comp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  comp_val_t        comp_arr_i,
  input  comp_idx_t        comp_ind_i,
  input  ips_t             inputs_per_slice_i,
  output dense_t           dense_arr_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] nz_count_o,
  output logic             err_o
);

  state_t             state_q;
  comp_val_t          compArr_q;
  comp_idx_t          compInd_q;
  ips_t               ips_q;
  logic [SLICE_W-1:0] sliceIdx_q;
  logic [ENTRY_W-1:0] entryIdx_q;
  logic [POS_W:0]     posNext_q;
  logic [POS_W:0]     posNext_d;
  logic               inReady_q;
  logic               outValid_q;
  logic               err_q;
  logic [CNT_W-1:0]   nzCount_q;

  logic [CNT_W-1:0]   curIps;
  logic [ENTRY_W-1:0] sliceLen;
  logic               sliceOver;
  logic               entryActive;
  logic [IDX_W-1:0]   curIdx;
  logic [DATA_W-1:0]  curVal;
  logic [SUM_W-1:0]   pos;
  logic               posInRange;
  logic               bufWe;
  logic               bufClear;

  // Zero runs carry across slices, so the position is always relative to the
  // last non-zero written; once past the end it stays pinned there.
  always_comb begin
    curIps      = ips_q[sliceIdx_q];
    sliceLen    = clampLen(curIps);
    sliceOver   = curIps > CNT_W'(SLICE_LEN);
    entryActive = (state_q == DECODE) && (entryIdx_q < sliceLen);
    curIdx      = compInd_q[sliceIdx_q][entryIdx_q[ENTRY_W-2:0]];
    curVal      = compArr_q[sliceIdx_q][entryIdx_q[ENTRY_W-2:0]];
    pos         = SUM_W'(posNext_q) + SUM_W'(curIdx);
    posInRange  = pos < SUM_W'(DENSE_LEN);
    posNext_d   = posInRange ? (pos[POS_W:0] + (POS_W+1)'(1)) : (POS_W+1)'(DENSE_LEN);
    bufWe       = entryActive && posInRange;
    bufClear    = (state_q == IDLE) && in_valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      compArr_q  <= '0;
      compInd_q  <= '0;
      ips_q      <= '0;
      sliceIdx_q <= '0;
      entryIdx_q <= '0;
      posNext_q  <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
      nzCount_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            compArr_q  <= comp_arr_i;
            compInd_q  <= comp_ind_i;
            ips_q      <= inputs_per_slice_i;
            sliceIdx_q <= '0;
            entryIdx_q <= '0;
            posNext_q  <= '0;
            nzCount_q  <= '0;
            err_q      <= 1'b0;
            inReady_q  <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          if (sliceOver) err_q <= 1'b1;
          if (entryActive) begin
            if (posInRange) nzCount_q <= nzCount_q + CNT_W'(1);
            else            err_q     <= 1'b1;
            posNext_q  <= posNext_d;
            entryIdx_q <= entryIdx_q + ENTRY_W'(1);
          end else begin
            entryIdx_q <= '0;
            if (sliceIdx_q == SLICE_W'(NUM_SLICES - 1)) state_q <= DONE;
            else sliceIdx_q <= sliceIdx_q + SLICE_W'(1);
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE.
          outValid_q <= 1'b1;
          if (outValid_q && out_ready_i) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  scnn_dense_buf u_dense_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (bufClear),
    .we_i    (bufWe),
    .waddr_i (pos[POS_W-1:0]),
    .wdata_i (curVal),
    .rdata_o (dense_arr_o)
  );

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign nz_count_o  = nzCount_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_scnn_decompression_ips.sv
// Directed vector table plus hand-written backpressure/reset sequence for the
// SCNN decompressor.
module tb_scnn_decompression_ips;
  import scnn_comp_pkg::*;

  localparam int NUM_VECS = 11;
  localparam int MAX_WAIT = 200;

  typedef struct {
    comp_val_t        arr;
    comp_idx_t        ind;
    ips_t             ips;
    dense_t           expDense;
    logic [CNT_W-1:0] expNz;
    logic             expErr;
    int               expLat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  comp_val_t        comp_arr;
  comp_idx_t        comp_ind;
  ips_t             ips;
  dense_t           dense_arr;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] nz_count;
  logic             err;

  vec_t vecs[NUM_VECS];
  vec_t rf;
  int   compCount = 0;
  int   missCount = 0;
  int   latency;
  bit   timedOut;

  always #5 clk = ~clk;

  scnn_decompression_ips dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .comp_arr_i         (comp_arr),
    .comp_ind_i         (comp_ind),
    .inputs_per_slice_i (ips),
    .dense_arr_o        (dense_arr),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .nz_count_o         (nz_count),
    .err_o              (err)
  );

  function automatic vec_t emptyVec();
    vec_t v;
    v.arr      = '0;
    v.ind      = '0;
    v.ips      = '0;
    v.expDense = '0;
    v.expNz    = '0;
    v.expErr   = 1'b0;
    v.expLat   = NUM_SLICES + 1;
    return v;
  endfunction

  // Random dense vector pushed through a reference compressor; the decoder
  // must hand back the original.
  function automatic vec_t buildRoundTrip(input int sparsePct);
    vec_t   v;
    dense_t orig;
    int     run;
    int     n;
    int     s;
    int     k;
    v    = emptyVec();
    orig = '0;
    for (int i = 0; i < DENSE_LEN; i++)
      if (int'($urandom_range(99)) >= sparsePct) orig[i] = 16'($urandom_range(65535, 1));
    run = 0;
    n   = 0;
    for (int i = 0; i < DENSE_LEN; i++) begin
      if (orig[i] != '0) begin
        s = i / SLICE_LEN;
        k = int'(v.ips[s]);
        v.arr[s][k] = orig[i];
        v.ind[s][k] = IDX_W'(run);
        v.ips[s]    = v.ips[s] + CNT_W'(1);
        run = 0;
        n++;
      end else begin
        run++;
      end
    end
    v.expDense = orig;
    v.expNz    = CNT_W'(n);
    v.expLat   = n + NUM_SLICES + 1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkDense(input string name, input dense_t exp);
    int bad;
    bad = 0;
    for (int i = DENSE_LEN - 1; i >= 0; i--)
      if (dense_arr[i] !== exp[i]) bad = i;
    checkOutput($sformatf("%s dense[%0d]", name, bad), 32'(dense_arr[bad]), 32'(exp[bad]));
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int v);
    int waitCnt;
    timedOut = 1'b0;
    @(negedge clk);
    waitCnt = 0;
    while (!in_ready && waitCnt < MAX_WAIT) begin
      @(negedge clk);
      waitCnt++;
    end
    comp_arr = vecs[v].arr;
    comp_ind = vecs[v].ind;
    ips      = vecs[v].ips;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble the inputs: only the accept edge may sample them.
    comp_arr = '1;
    comp_ind = '0;
    ips      = '1;
    latency  = 0;
    while (!out_valid && latency < MAX_WAIT) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
    end
    if (latency >= MAX_WAIT) timedOut = 1'b1;
  endtask

  task automatic checkVector(input int v);
    string tag;
    tag = $sformatf("vec%0d", v);
    checkOutput({tag, " latency"}, 32'(latency), 32'(vecs[v].expLat));
    checkDense(tag, vecs[v].expDense);
    checkOutput({tag, " nz_count"}, 32'(nz_count), 32'(vecs[v].expNz));
    checkOutput({tag, " err"}, 32'(err), 32'(vecs[v].expErr));
    checkOutput({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("out_valid after handshake", 32'(out_valid), 32'd0);
    checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NUM_VECS; i++) vecs[i] = emptyVec();

    // 0: sparse frame, values at 0, 17 and 63.
    vecs[0].ips[0] = 1;  vecs[0].arr[0][0] = 16'h000A; vecs[0].ind[0][0] = 0;
    vecs[0].ips[1] = 1;  vecs[0].arr[1][0] = 16'h000B; vecs[0].ind[1][0] = 16;
    vecs[0].ips[3] = 1;  vecs[0].arr[3][0] = 16'h000C; vecs[0].ind[3][0] = 45;
    vecs[0].expDense[0] = 16'h000A; vecs[0].expDense[17] = 16'h000B; vecs[0].expDense[63] = 16'h000C;
    vecs[0].expNz = 3; vecs[0].expLat = 8;

    // 1: fully dense frame.
    for (int s = 0; s < NUM_SLICES; s++) begin
      vecs[1].ips[s] = 16;
      for (int k = 0; k < SLICE_LEN; k++) vecs[1].arr[s][k] = 16'(s * SLICE_LEN + k + 1);
    end
    for (int i = 0; i < DENSE_LEN; i++) vecs[1].expDense[i] = 16'(i + 1);
    vecs[1].expNz = 64; vecs[1].expLat = 69;

    // 2: zero run past the end of the vector.
    vecs[2].ips[0] = 1; vecs[2].arr[0][0] = 16'h0777; vecs[2].ind[0][0] = 200;
    vecs[2].expErr = 1'b1; vecs[2].expLat = 6;

    // 3: slice count of 20 clamps to 16.
    vecs[3].ips[2] = 20;
    for (int k = 0; k < SLICE_LEN; k++) begin
      vecs[3].arr[2][k]   = 16'(16'h0100 + k);
      vecs[3].expDense[k] = 16'(16'h0100 + k);
    end
    vecs[3].expNz = 16; vecs[3].expErr = 1'b1; vecs[3].expLat = 21;

    // 4: empty frame stays as emptyVec.

    // 5: zero-valued entry is written and counted.
    vecs[5].ips[0] = 2;
    vecs[5].arr[0][0] = 16'h0000; vecs[5].ind[0][0] = 3;
    vecs[5].arr[0][1] = 16'h0055; vecs[5].ind[0][1] = 0;
    vecs[5].expDense[4] = 16'h0055;
    vecs[5].expNz = 2; vecs[5].expLat = 7;

    // 6: zero run continues into the next slice.
    vecs[6].ips[0] = 1; vecs[6].arr[0][0] = 16'h0007; vecs[6].ind[0][0] = 10;
    vecs[6].ips[1] = 1; vecs[6].arr[1][0] = 16'h0008; vecs[6].ind[1][0] = 5;
    vecs[6].expDense[10] = 16'h0007; vecs[6].expDense[16] = 16'h0008;
    vecs[6].expNz = 2; vecs[6].expLat = 7;

    // 7: entry right after position 63 falls off the end.
    vecs[7].ips[0] = 2;
    vecs[7].arr[0][0] = 16'h0001; vecs[7].ind[0][0] = 63;
    vecs[7].arr[0][1] = 16'h0002; vecs[7].ind[0][1] = 0;
    vecs[7].expDense[63] = 16'h0001;
    vecs[7].expNz = 1; vecs[7].expErr = 1'b1; vecs[7].expLat = 7;

    vecs[8]  = buildRoundTrip(0);
    vecs[9]  = buildRoundTrip(50);
    vecs[10] = buildRoundTrip(90);

    // Frame used to check that reset aborts a decode in progress.
    rf = emptyVec();
    rf.ips[0] = 2;
    rf.arr[0][0] = 16'h1234; rf.ind[0][0] = 0;
    rf.arr[0][1] = 16'h9999; rf.ind[0][1] = 250;
    rf.ips[1] = 16;
    for (int k = 0; k < SLICE_LEN; k++) rf.arr[1][k] = 16'(16'h2000 + k);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    comp_arr  = '0;
    comp_ind  = '0;
    ips       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset nz_count", 32'(nz_count), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkDense("reset", '0);

    for (int v = 0; v < NUM_VECS; v++) begin
      applyStimulus(v);
      checkVector(v);
      if (timedOut) resetDut();
      else handshake();
    end

    // Backpressure: DONE must hold steady and ignore in_valid.
    applyStimulus(0);
    checkVector(0);
    comp_arr = rf.arr;
    comp_ind = rf.ind;
    ips      = rf.ips;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("bp cycle%0d out_valid", c), 32'(out_valid), 32'd1);
      checkDense($sformatf("bp cycle%0d", c), vecs[0].expDense);
    end
    checkOutput("bp nz_count", 32'(nz_count), 32'd3);
    handshake();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("accept after handshake in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-decode nz_count", 32'(nz_count), 32'd1);
    checkOutput("mid-decode err", 32'(err), 32'd1);
    checkOutput("mid-decode dense[0]", 32'(dense_arr[0]), 32'h1234);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort nz_count", 32'(nz_count), 32'd0);
    checkOutput("abort err", 32'(err), 32'd0);
    checkDense("abort", '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("abort stays idle out_valid", 32'(out_valid), 32'd0);

    applyStimulus(4);
    checkVector(4);
    if (timedOut) resetDut();
    else handshake();

    $display("== %0d vectors applied, %0d miscompares ==", compCount, missCount);
    $finish;
  end

endmodule
